imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the combinational instruction memory's byte address. It fetches one word per cycle into a 2-entry queue and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects (with flush) and halt. It sits between the instruction memory and the decode stage.

---
 rtl/imem_fetch_ctrl_pkg.sv | 23 ++
 rtl/imem_fetch_ctrl_queue.sv | 65 ++++++
 rtl/imem_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer and its queue.
// Holds the fetch FSM state encoding and the helper that turns a
// log2(bytes-per-word) value into the PC increment, so every stage that
// walks instruction addresses agrees on the step size.
// ---------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    // Fetch sequencer states: BOOT is a single idle cycle after reset,
    // FETCH is normal streaming, HALTED stops fetching until a redirect.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // Byte distance between consecutive instruction words.
    function automatic int word_step(input int wordbits);
        return 1 << wordbits;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Two-entry synchronous FIFO sitting between instruction fetch and decode.
// Ports:
//   clk    - clock, all updates on rising edge
//   reset  - synchronous active-high reset, empties the queue
//   push   - write din at the tail this cycle
//   pop    - drop the head entry this cycle
//   flush  - discard all entries (wins over push/pop)
//   din    - entry to enqueue
//   dout   - current head entry (meaningless while count is zero)
//   count  - number of valid entries, 0..2
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int WIDTH = 45
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;

    // Pointer and occupancy tracking. A push and pop together while full
    // writes the slot being vacated by the head, which then becomes the
    // tail, so FIFO order survives the simultaneous case.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer. Owns the program counter, drives the
// combinational instruction memory address, buffers fetched words in a
// two-entry queue and hands them to decode over a valid/ready handshake.
// Also handles redirects (flush + restart) and halt.
// Ports:
//   CLK, RESET     - clock and synchronous active-high reset
//   IMEM_ADDR      - byte address to instruction memory (the PC)
//   IMEM_INSTR     - word returned by memory for IMEM_ADDR, same cycle
//   INSTR_OUT      - head instruction to decode
//   PC_OUT         - byte address of INSTR_OUT
//   VALID_OUT      - head entry valid
//   READY_IN       - decode accepts the head this cycle
//   REDIRECT       - flush queue and restart fetch at REDIRECT_PC
//   REDIRECT_PC    - redirect byte address (low word bits ignored)
//   HALT_REQ       - stop fetching and enter HALTED
//   HALTED         - high while in HALTED state
//   DELIVERED_CNT  - number of completed decode handshakes (wraps)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int ADDRBITS = 13,
    parameter int WORDBITS = 2,
    parameter int START_PC = 0,
    parameter int CNTBITS  = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic [ADDRBITS-1:0] IMEM_ADDR,
    input  logic [DBITS-1:0]    IMEM_INSTR,
    output logic [DBITS-1:0]    INSTR_OUT,
    output logic [ADDRBITS-1:0] PC_OUT,
    output logic                VALID_OUT,
    input  logic                READY_IN,
    input  logic                REDIRECT,
    input  logic [ADDRBITS-1:0] REDIRECT_PC,
    input  logic                HALT_REQ,
    output logic                HALTED,
    output logic [CNTBITS-1:0]  DELIVERED_CNT
);

    localparam int QWIDTH = DBITS + ADDRBITS;
    localparam logic [ADDRBITS-1:0] LOW_MASK = ADDRBITS'(word_step(WORDBITS) - 1);
    localparam logic [ADDRBITS-1:0] PC_STEP  = ADDRBITS'(word_step(WORDBITS));
    localparam logic [ADDRBITS-1:0] RESET_PC = ADDRBITS'(START_PC) & ~LOW_MASK;

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [ADDRBITS-1:0] pc_q;
    logic [CNTBITS-1:0]  cnt_q;
    logic [1:0]          q_count;
    logic [QWIDTH-1:0]   q_dout;
    logic                head_valid;
    logic                do_pop;
    logic                do_fetch;

    // Handshake and fetch qualification. A redirect hides the head so
    // nothing stale is accepted in the flush cycle, and fetch is allowed
    // into a full queue only when the head leaves in the same cycle.
    assign head_valid = (q_count != 2'd0) && !REDIRECT;
    assign do_pop     = head_valid && READY_IN;
    assign do_fetch   = (state_q == ST_FETCH) && !HALT_REQ && !REDIRECT
                        && ((q_count != 2'd2) || do_pop);

    fetch_queue #(
        .WIDTH (QWIDTH)
    ) u_queue (
        .clk   (CLK),
        .reset (RESET),
        .push  (do_fetch),
        .pop   (do_pop),
        .flush (REDIRECT),
        .din   ({IMEM_INSTR, pc_q}),
        .dout  (q_dout),
        .count (q_count)
    );

    // State register for the fetch sequencer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Redirect outranks halt; BOOT always moves on to
    // FETCH after its single idle cycle regardless of other inputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (REDIRECT) begin
                    state_d = ST_FETCH;
                end else if (HALT_REQ) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (REDIRECT) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Program counter: redirect target (word aligned) beats the normal
    // increment, and the increment wraps naturally at the address width.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else if (REDIRECT) begin
            pc_q <= REDIRECT_PC & ~LOW_MASK;
        end else if (do_fetch) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // Delivered-instruction counter, one step per completed handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (do_pop) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign IMEM_ADDR     = pc_q;
    assign INSTR_OUT     = q_dout[QWIDTH-1:ADDRBITS];
    assign PC_OUT        = q_dout[ADDRBITS-1:0];
    assign VALID_OUT     = head_valid;
    assign HALTED        = (state_q == ST_HALTED);
    assign DELIVERED_CNT = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed testbench for imem_fetch_ctrl. The instruction memory is modelled
// as word k = k at byte address 4k. Expected deliveries are queued by the
// stimulus; an independent monitor compares every decode handshake.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [12:0] pc;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic [12:0] IMEM_ADDR;
    logic [31:0] IMEM_INSTR;
    logic [31:0] INSTR_OUT;
    logic [12:0] PC_OUT;
    logic        VALID_OUT;
    logic        READY_IN;
    logic        REDIRECT;
    logic [12:0] REDIRECT_PC;
    logic        HALT_REQ;
    logic        HALTED;
    logic [31:0] DELIVERED_CNT;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    imem_fetch_ctrl #(
        .DBITS    (32),
        .ADDRBITS (13),
        .WORDBITS (2),
        .START_PC (0),
        .CNTBITS  (32)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_INSTR    (IMEM_INSTR),
        .INSTR_OUT     (INSTR_OUT),
        .PC_OUT        (PC_OUT),
        .VALID_OUT     (VALID_OUT),
        .READY_IN      (READY_IN),
        .REDIRECT      (REDIRECT),
        .REDIRECT_PC   (REDIRECT_PC),
        .HALT_REQ      (HALT_REQ),
        .HALTED        (HALTED),
        .DELIVERED_CNT (DELIVERED_CNT)
    );

    // Combinational instruction memory: word k holds the value k.
    assign IMEM_INSTR = 32'(IMEM_ADDR >> 2);

    // Free-running clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir,
                                 input logic [12:0] rpc, input logic halt);
        RESET       = rst;
        READY_IN    = rdy;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        HALT_REQ    = halt;
    endtask

    task automatic expectWord(input logic [31:0] instr, input logic [12:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // Apply a reset edge, release it and check the post-reset outputs.
    task automatic doReset(input logic rdy);
        applyStimulus(1'b1, rdy, 1'b0, 13'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, rdy, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("reset_valid", 32'(VALID_OUT), 32'd0);
        checkOutput("reset_halted", 32'(HALTED), 32'd0);
        checkOutput("reset_addr", 32'(IMEM_ADDR), 32'h0);
        checkOutput("reset_cnt", DELIVERED_CNT, 32'd0);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RESET && VALID_OUT && READY_IN) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_delivery: got instr 0x%0h pc 0x%0h, expected none",
                         INSTR_OUT, PC_OUT);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_instr", INSTR_OUT, e.instr);
                checkOutput("sb_pc", 32'(PC_OUT), 32'(e.pc));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 13'h0, 1'b0);

        // Test 1: boot and stream three words.
        $display("[TB] test 1: boot and stream");
        doReset(1'b1);
        expectWord(32'd0, 13'h000);
        expectWord(32'd1, 13'h004);
        expectWord(32'd2, 13'h008);
        nextCycle();
        sample();
        checkOutput("t1_boot_valid", 32'(VALID_OUT), 32'd0);
        nextCycle();
        sample();
        checkOutput("t1_addr", 32'(IMEM_ADDR), 32'h4);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t1_cnt", DELIVERED_CNT, 32'd3);

        // Test 2: back-pressure fills the queue, then release.
        $display("[TB] test 2: back-pressure");
        doReset(1'b0);
        nextCycle();
        nextCycle();
        sample();
        checkOutput("t2_addr_first", 32'(IMEM_ADDR), 32'h4);
        checkOutput("t2_valid_first", 32'(VALID_OUT), 32'd1);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            sample();
            checkOutput("t2_addr_stall", 32'(IMEM_ADDR), 32'h8);
            checkOutput("t2_instr_hold", INSTR_OUT, 32'd0);
            checkOutput("t2_pc_hold", 32'(PC_OUT), 32'h0);
        end
        nextCycle();
        expectWord(32'd0, 13'h000);
        expectWord(32'd1, 13'h004);
        expectWord(32'd2, 13'h008);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput("t2_no_gap", 32'(VALID_OUT), 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t2_cnt", DELIVERED_CNT, 32'd3);

        // Test 3: redirect with a full queue.
        $display("[TB] test 3: redirect flush");
        doReset(1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        expectWord(32'd0, 13'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h103, 1'b0);
        sample();
        checkOutput("t3_valid_redirect", 32'(VALID_OUT), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        expectWord(32'h40, 13'h100);
        sample();
        checkOutput("t3_addr", 32'(IMEM_ADDR), 32'h100);
        checkOutput("t3_valid_after", 32'(VALID_OUT), 32'd0);
        checkOutput("t3_cnt_kept", DELIVERED_CNT, 32'd1);
        nextCycle();
        sample();
        checkOutput("t3_valid_target", 32'(VALID_OUT), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t3_cnt", DELIVERED_CNT, 32'd2);
        checkOutput("t3_next_pc", 32'(PC_OUT), 32'h104);

        // Test 4: halt drains the queue, redirect resumes.
        $display("[TB] test 4: halt and resume");
        doReset(1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        expectWord(32'd0, 13'h000);
        expectWord(32'd1, 13'h004);
        sample();
        checkOutput("t4_halted", 32'(HALTED), 32'd1);
        checkOutput("t4_addr_frozen", 32'(IMEM_ADDR), 32'h8);
        nextCycle();
        sample();
        checkOutput("t4_drain_valid", 32'(VALID_OUT), 32'd1);
        checkOutput("t4_addr_frozen2", 32'(IMEM_ADDR), 32'h8);
        nextCycle();
        sample();
        checkOutput("t4_empty", 32'(VALID_OUT), 32'd0);
        checkOutput("t4_addr_frozen3", 32'(IMEM_ADDR), 32'h8);
        checkOutput("t4_cnt_drain", DELIVERED_CNT, 32'd2);
        checkOutput("t4_still_halted", 32'(HALTED), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h040, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        expectWord(32'h10, 13'h040);
        sample();
        checkOutput("t4_unhalted", 32'(HALTED), 32'd0);
        checkOutput("t4_resume_addr", 32'(IMEM_ADDR), 32'h40);
        nextCycle();
        sample();
        checkOutput("t4_resume_valid", 32'(VALID_OUT), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t4_cnt", DELIVERED_CNT, 32'd3);

        // Test 5: redirect during BOOT to the top word, then address wrap.
        $display("[TB] test 5: address wrap");
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 13'h1FFC, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
        expectWord(32'h7FF, 13'h1FFC);
        expectWord(32'd0, 13'h000);
        sample();
        checkOutput("t5_addr_top", 32'(IMEM_ADDR), 32'h1FFC);
        checkOutput("t5_not_halted", 32'(HALTED), 32'd0);
        nextCycle();
        sample();
        checkOutput("t5_addr_wrap", 32'(IMEM_ADDR), 32'h0);
        checkOutput("t5_pc_top", 32'(PC_OUT), 32'h1FFC);
        nextCycle();
        sample();
        checkOutput("t5_pc_wrap", 32'(PC_OUT), 32'h0);
        checkOutput("t5_addr_next", 32'(IMEM_ADDR), 32'h4);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t5_valid", 32'(VALID_OUT), 32'd1);
        checkOutput("t5_cnt", DELIVERED_CNT, 32'd2);

        // Test 6: reset mid-stream together with redirect and halt.
        $display("[TB] test 6: reset overrides redirect");
        applyStimulus(1'b1, 1'b0, 1'b1, 13'h080, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
        sample();
        checkOutput("t6_valid", 32'(VALID_OUT), 32'd0);
        checkOutput("t6_halted", 32'(HALTED), 32'd0);
        checkOutput("t6_addr", 32'(IMEM_ADDR), 32'h0);
        checkOutput("t6_cnt", DELIVERED_CNT, 32'd0);
        nextCycle();
        sample();
        checkOutput("t6_boot_addr", 32'(IMEM_ADDR), 32'h0);
        checkOutput("t6_boot_valid", 32'(VALID_OUT), 32'd0);

        nextCycle();
        nextCycle();
        checkOutput("sb_all_delivered", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
